// File: rtl/flash_store_if.sv
// flash_store_if: core-to-store bus (address, write/erase requests, read data and status)
interface flash_if #(parameter int DATA_W = 256, parameter int ADDR_W = 4);
  logic [ADDR_W-1:0] add_flash;
  logic              flash_write;
  logic [DATA_W-1:0] write_data_flash;
  logic              erase;
  logic [DATA_W-1:0] data_flash;
  logic [ADDR_W-1:0] max_address;
  logic [ADDR_W:0]   entry_count;
  logic              empty;
  logic              full;
  logic              busy;
  logic              wr_err;
  logic              par_err;
  modport master(output add_flash, flash_write, write_data_flash, erase,
                 input data_flash, max_address, entry_count, empty, full, busy, wr_err, par_err);
  modport slave(input add_flash, flash_write, write_data_flash, erase,
                output data_flash, max_address, entry_count, empty, full, busy, wr_err, par_err);
endinterface

// File: rtl/flash_store.sv
// flash_store: record store with emulated program/erase busy time; FLASH_PARITY_EN adds per-record even parity
module flash_store #(
  parameter int DATA_W      = 256,
  parameter int ADDR_W      = 4,
  parameter int PROG_CYCLES = 4
) (
  input logic   clk,
  input logic   rst,
  flash_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW = $clog2(PROG_CYCLES + 1);
`ifdef FLASH_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  localparam logic [1:0] IDLE = 2'd0, PROG = 2'd1, ERASE = 2'd2;
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              app_q, app_d;
  logic              wr_err_q, wr_err_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_q, par_d;
  logic [MW-1:0]     mem_q [DEPTH];
  logic              mem_we;
  logic [MW-1:0]     mem_wd;
  logic idle, valid_rd, is_full, accept, prog_last, erase_last;
  assign idle       = state_q == IDLE;
  assign valid_rd   = {1'b0, bus.add_flash} < count_q;
  assign is_full    = count_q == (ADDR_W+1)'(DEPTH);
  assign accept     = idle && !bus.erase && bus.flash_write &&
                      (valid_rd || ({1'b0, bus.add_flash} == count_q && !is_full));
  assign prog_last  = state_q == PROG && cnt_q == '0;
  assign erase_last = state_q == ERASE && addr_q == ADDR_W'(DEPTH - 1);
  // next-state: request acceptance, program countdown, erase sweep, read path
  always_comb begin
    state_d  = idle ? (bus.erase ? ERASE : accept ? PROG : IDLE) :
               (prog_last || erase_last) ? IDLE : state_q;
    cnt_d    = accept ? CW'(PROG_CYCLES - 1) : state_q == PROG ? cnt_q - 1'b1 : cnt_q;
    addr_d   = accept ? bus.add_flash : (idle && bus.erase) ? '0 :
               state_q == ERASE ? addr_q + 1'b1 : addr_q;
    wdata_d  = accept ? bus.write_data_flash : wdata_q;
    app_d    = accept ? !valid_rd : app_q;
    count_d  = erase_last ? '0 : (prog_last && app_q) ? count_q + 1'b1 : count_q;
    wr_err_d = (!idle && (bus.flash_write || bus.erase)) || (idle && bus.flash_write && !accept);
    data_d   = valid_rd ? mem_q[bus.add_flash][DATA_W-1:0] : '0;
`ifdef FLASH_PARITY_EN
    par_d    = valid_rd && ^mem_q[bus.add_flash];
    mem_wd   = state_q == ERASE ? '0 : {^wdata_q, wdata_q};
`else
    par_d    = 1'b0;
    mem_wd   = state_q == ERASE ? '0 : wdata_q;
`endif
    mem_we   = prog_last || state_q == ERASE;
  end
  // control and output registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      app_q    <= 1'b0;
      wr_err_q <= 1'b0;
      data_q   <= '0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      app_q    <= app_d;
      wr_err_q <= wr_err_d;
      data_q   <= data_d;
      par_q    <= par_d;
    end
  end
  // record array keeps its contents through reset; reset only blocks the write
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[addr_q] <= mem_wd;
  end
  assign bus.data_flash  = data_q;
  assign bus.entry_count = count_q;
  assign bus.max_address = count_q == '0 ? '0 : count_q[ADDR_W-1:0] - 1'b1;
  assign bus.empty       = count_q == '0;
  assign bus.full        = is_full;
  assign bus.busy        = !idle;
  assign bus.wr_err      = wr_err_q;
  assign bus.par_err     = par_q;
endmodule

// File: tb/tb_flash_store.sv
// tb_flash_store: directed table, corner sequences and random traffic checked against a cycle model
module tb_flash_store;
  localparam int PROG = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  flash_if #(.DATA_W(256), .ADDR_W(4)) bus();
  flash_store #(.DATA_W(256), .ADDR_W(4), .PROG_CYCLES(PROG)) dut(.clk(clk), .rst(rst), .bus(bus));
  int errors = 0;
  int checks = 0;
  logic [255:0] m_mem [16];
  int m_cnt = 0, m_left = 0, m_kind = 0, m_addr = 0;
  logic [255:0] m_dat;
  bit m_app;
  logic [255:0] e_data;
  bit e_err;
  typedef struct {
    logic [3:0]   a;
    logic         w;
    logic         e;
    logic [255:0] d;
    logic         busy;
    logic [4:0]   cnt;
    logic         err;
    logic [255:0] q;
  } vec_t;
  vec_t tbl [19];
  function automatic logic [255:0] rec(input logic [7:0] k);
    return {32{k}};
  endfunction
  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  function automatic vec_t mk(input logic [3:0] a, input logic w, input logic e, input logic [255:0] d,
                              input logic busy, input logic [4:0] cnt, input logic err, input logic [255:0] q);
    vec_t v;
    v.a = a; v.w = w; v.e = e; v.d = d; v.busy = busy; v.cnt = cnt; v.err = err; v.q = q;
    return v;
  endfunction
  task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  // one clock edge of the behavioural store: busy time counted in remaining cycles
  task automatic model(input logic [3:0] a, input logic w, input logic [255:0] d, input logic e, input logic r);
    if (r) begin
      m_cnt = 0; m_left = 0; e_data = '0; e_err = 0;
      return;
    end
    e_data = (int'(a) < m_cnt) ? m_mem[a] : '0;
    if (m_left > 0) begin
      e_err = w || e;
      m_left--;
      if (m_kind == 2) begin
        m_mem[15 - m_left] = '0;
        if (m_left == 0) m_cnt = 0;
      end else if (m_left == 0) begin
        m_mem[m_addr] = m_dat;
        if (m_app) m_cnt++;
      end
    end else if (e) begin
      e_err = w; m_kind = 2; m_left = 16;
    end else if (w) begin
      if (int'(a) < m_cnt || (int'(a) == m_cnt && m_cnt < 16)) begin
        e_err = 0; m_kind = 1; m_left = PROG; m_addr = int'(a); m_dat = d; m_app = (int'(a) == m_cnt);
      end else e_err = 1;
    end else e_err = 0;
  endtask
  task automatic step(input logic [3:0] a, input logic w, input logic [255:0] d, input logic e, input logic r);
    logic [3:0] mx;
    @(negedge clk);
    bus.add_flash = a; bus.flash_write = w; bus.write_data_flash = d; bus.erase = e; rst = r;
    @(posedge clk);
    model(a, w, d, e, r);
    #1;
    mx = m_cnt == 0 ? 4'd0 : 4'(m_cnt - 1);
    chk("data_flash", bus.data_flash, e_data);
    chk("entry_count", 256'(bus.entry_count), 256'(m_cnt));
    chk("busy", 256'(bus.busy), 256'(m_left > 0));
    chk("wr_err", 256'(bus.wr_err), 256'(e_err));
    chk("empty_full_max", 256'({bus.empty, bus.full, bus.max_address}), 256'({m_cnt == 0, m_cnt == 16, mx}));
    chk("par_err", 256'(bus.par_err), 256'(0));
  endtask
  initial begin
    bus.add_flash = '0; bus.flash_write = 1'b0; bus.write_data_flash = '0; bus.erase = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    tbl[0]  = mk(0, 1, 0, rec(8'hA0), 1, 0, 0, '0);
    tbl[1]  = mk(0, 0, 0, '0,          1, 0, 0, '0);
    tbl[2]  = mk(0, 0, 0, '0,          1, 0, 0, '0);
    tbl[3]  = mk(1, 1, 0, rec(8'h77), 1, 0, 1, '0);
    tbl[4]  = mk(0, 0, 0, '0,          0, 1, 0, '0);
    tbl[5]  = mk(1, 1, 0, rec(8'hA1), 1, 1, 0, '0);
    tbl[6]  = mk(0, 0, 0, '0,          1, 1, 0, rec(8'hA0));
    tbl[7]  = mk(3, 1, 0, rec(8'h77), 1, 1, 1, '0);
    tbl[8]  = mk(0, 0, 0, '0,          1, 1, 0, rec(8'hA0));
    tbl[9]  = mk(1, 0, 0, '0,          0, 2, 0, '0);
    tbl[10] = mk(1, 0, 0, '0,          0, 2, 0, rec(8'hA1));
    tbl[11] = mk(3, 1, 0, rec(8'h77), 0, 2, 1, '0);
    tbl[12] = mk(0, 1, 0, rec(8'hB0), 1, 2, 0, rec(8'hA0));
    tbl[13] = mk(0, 0, 0, '0,          1, 2, 0, rec(8'hA0));
    tbl[14] = mk(0, 0, 0, '0,          1, 2, 0, rec(8'hA0));
    tbl[15] = mk(0, 0, 0, '0,          1, 2, 0, rec(8'hA0));
    tbl[16] = mk(0, 0, 0, '0,          0, 2, 0, rec(8'hA0));
    tbl[17] = mk(0, 0, 0, '0,          0, 2, 0, rec(8'hB0));
    tbl[18] = mk(1, 1, 1, rec(8'h77), 1, 2, 1, rec(8'hA1));
    // reset, then every address reads zero on an empty store
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 1);
    for (int i = 0; i < 16; i++) step(4'(i), 0, '0, 0, 0);
    // directed appends, rejects and overwrite, ending in erase-beats-write
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].e, 0);
      chk($sformatf("tbl%0d_busy", i), 256'(bus.busy), 256'(tbl[i].busy));
      chk($sformatf("tbl%0d_cnt", i), 256'(bus.entry_count), 256'(tbl[i].cnt));
      chk($sformatf("tbl%0d_err", i), 256'(bus.wr_err), 256'(tbl[i].err));
      chk($sformatf("tbl%0d_data", i), bus.data_flash, tbl[i].q);
    end
    // erase runs 16 busy cycles in total
    for (int i = 0; i < 15; i++) step(1, 0, '0, 0, 0);
    chk("erase_busy_tail", 256'(bus.busy), 256'(1));
    step(1, 0, '0, 0, 0);
    chk("erase_done", 256'({bus.busy, bus.empty}), 256'(2'b01));
    for (int i = 0; i < 16; i++) step(4'(i), 0, '0, 0, 0);
    // fill all 16 records
    for (int i = 0; i < 16; i++) begin
      step(4'(i), 1, rec(8'(8'h10 + i)), 0, 0);
      repeat (PROG) step(4'(i), 0, '0, 0, 0);
    end
    chk("full_max", 256'({bus.full, bus.max_address}), 256'(5'h1F));
    // append past the end wraps to address 0, an overwrite
    step(0, 1, rec(8'hEE), 0, 0);
    repeat (PROG + 1) step(0, 0, '0, 0, 0);
    chk("wrap_overwrite", bus.data_flash, rec(8'hEE));
    chk("wrap_count", 256'(bus.entry_count), 256'(16));
    // reset during erase cycle 5 leaves records 5..15
    step(0, 0, '0, 1, 0);
    repeat (5) step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("retain%0d", i), dut.mem_q[i][255:0], i < 5 ? 256'(0) : rec(8'(8'h10 + i)));
    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] a;
      a = ($urandom % 2) ? 4'(m_cnt) : 4'($urandom);
      step(a, ($urandom % 3) == 0, rnd256(), ($urandom % 60) == 0, ($urandom % 250) == 0);
    end
`ifdef FLASH_PARITY_EN
    step(0, 0, '0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(4'(i), 1, rec(8'(8'h50 + i)), 0, 0);
      repeat (PROG) step(4'(i), 0, '0, 0, 0);
    end
    dut.mem_q[2][0] = ~dut.mem_q[2][0];
    @(negedge clk); bus.add_flash = 4'd2;
    @(posedge clk); #1;
    chk("par_err_bad", 256'(bus.par_err), 256'(1));
    chk("par_data", bus.data_flash, rec(8'h52) ^ 256'(1));
    @(negedge clk); bus.add_flash = 4'd1;
    @(posedge clk); #1;
    chk("par_err_good", 256'(bus.par_err), 256'(0));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
